// File: rtl/sqrt_feeder_if.sv
// Handshake and sqrt32-core signals of sqrt_feeder, bundled as one interface.
// master = the feeder itself; slave = its surroundings (producer, sqrt32 core, consumer).
interface sqrt_feeder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        sq_reset;
  logic [31:0] sq_x;
  logic        sq_rdy;
  logic [15:0] sq_y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
  logic        err;

  modport master (
    input  in_valid, in_data, sq_rdy, sq_y, out_ready,
    output in_ready, sq_reset, sq_x, out_valid, out_data, busy, err
  );

  modport slave (
    output in_valid, in_data, sq_rdy, sq_y, out_ready,
    input  in_ready, sq_reset, sq_x, out_valid, out_data, busy, err
  );
endinterface

// File: rtl/sqrt_feeder.sv
// sqrt_feeder: operand FIFO plus a sequencer that starts a sqrt32 core per radicand and returns results.
// Define SQRT_FEED_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles with result 16'hFFFF and err set.
module sqrt_feeder #(
  parameter int DEPTH   = 4,
  parameter int HOLD    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  sqrt_feeder_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full, empty, push, pop;
  logic [31:0]   head;
  logic [31:0]   sq_x_q, sq_x_d;
  logic [15:0]   out_data_q, out_data_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          first_q;
  logic          sq_reset_q;

`ifdef SQRT_FEED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          tmo_hit;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.in_valid && !full;
  assign head  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    sq_x_d     = sq_x_q;
    out_data_d = out_data_q;
    hold_d     = hold_q;
    pop        = 1'b0;
`ifdef SQRT_FEED_TIMEOUT_EN
    err_d      = err_q;
    tmo_d      = '0;
`endif
    case (state_q)
      IDLE: begin
        if (!empty) begin
          sq_x_d  = head;
          pop     = 1'b1;
          hold_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (hold_q == HW'(HOLD - 1)) state_d = WAIT;
        else                         hold_d  = hold_q + HW'(1);
      end
      WAIT: begin
`ifdef SQRT_FEED_TIMEOUT_EN
        tmo_d = tmo_q + TW'(1);
`endif
        // rdy may still reflect the previous operation on the first WAIT cycle
        if (!first_q && bus.sq_rdy) begin
          out_data_d = bus.sq_y;
          state_d    = OUT;
        end
`ifdef SQRT_FEED_TIMEOUT_EN
        else if (tmo_hit) begin
          out_data_d = 16'hFFFF;
          err_d      = 1'b1;
          state_d    = OUT;
        end
`endif
      end
      OUT: begin
        if (bus.out_ready) begin
`ifdef SQRT_FEED_TIMEOUT_EN
          err_d = 1'b0;
`endif
          if (!empty) begin
            sq_x_d  = head;
            pop     = 1'b1;
            hold_d  = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sq_x_q     <= '0;
      out_data_q <= '0;
      hold_q     <= '0;
      first_q    <= 1'b0;
      sq_reset_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      sq_x_q     <= sq_x_d;
      out_data_q <= out_data_d;
      hold_q     <= hold_d;
      first_q    <= (state_q == START);
      sq_reset_q <= (state_d == START);
    end
  end

`ifdef SQRT_FEED_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.in_ready  = !full;
  assign bus.sq_reset  = sq_reset_q;
  assign bus.sq_x      = sq_x_q;
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_sqrt_feeder.sv
// Scoreboard bench for sqrt_feeder with a behavioural sqrt32 core of random latency.
// Expected results are queued on operand acceptance and popped by an output monitor.
module tb_sqrt_feeder;
  localparam int DEPTH   = 4;
  localparam int HOLD    = 2;
  localparam int TIMEOUT = 64;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  sqrt_feeder_if bus();

  sqrt_feeder #(.DEPTH(DEPTH), .HOLD(HOLD), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // floor(sqrt(x)) by binary search over the result range
  function automatic logic [15:0] ref_sqrt(input logic [31:0] x);
    longint lo, hi, mid;
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(x)) lo = mid;
      else                          hi = mid - 1;
    end
    return lo[15:0];
  endfunction

  // sqrt32 core model: restarts while sq_reset is high, answers after a random delay
  logic        stub_rdy = 1'b0;
  logic [15:0] stub_y   = 16'h0;
  logic [31:0] stub_x   = 32'h0;
  int          stub_cnt = 0;
  bit          stub_stuck = 1'b0;
  assign bus.sq_rdy = stub_rdy;
  assign bus.sq_y   = stub_y;

  always @(posedge clk) begin
    if (bus.sq_reset) begin
      stub_x   <= bus.sq_x;
      stub_rdy <= 1'b0;
      stub_cnt <= int'($urandom_range(1, 8));
    end else if (stub_stuck) begin
      stub_rdy <= 1'b0;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
    end else begin
      stub_rdy <= 1'b1;
      stub_y   <= ref_sqrt(stub_x);
    end
  end

  // consumer: forced level or random back-pressure, changed just after the rising edge
  bit ready_force = 1'b1;
  bit ready_val   = 1'b1;
  always @(posedge clk) begin
    #1;
    bus.out_ready <= ready_force ? ready_val : ($urandom_range(0, 3) != 0);
  end

  // start pulse width and sq_x stability while the core is being started
  int          run = 0;
  logic [31:0] x_start = 32'h0;
  always @(negedge clk) begin
    if (reset) begin
      run <= 0;
    end else if (bus.sq_reset && bus.busy) begin
      run <= run + 1;
      if (run == 0) x_start <= bus.sq_x;
      else          check("sq_x_in_start", bus.sq_x, x_start);
    end else if (run != 0) begin
      check("sq_reset_width", run, HOLD);
      run <= 0;
    end
  end

  // output monitor
  logic        hold_seen = 1'b0;
  logic [15:0] hold_data = 16'h0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      hold_seen <= 1'b0;
    end else begin
      if (hold_seen && bus.out_valid) check("out_data_stable", bus.out_data, hold_data);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("exp_available", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          $display("txn x=%h y=%h err=%b", bus.sq_x, bus.out_data, bus.err);
          check("out_data", bus.out_data, e.data);
          check("err", bus.err, e.err);
          check("sq_x_held", bus.sq_x, x_start);
        end
      end
      hold_seen <= bus.out_valid && !bus.out_ready;
      hold_data <= bus.out_data;
    end
  end

  task automatic push_op(input logic [31:0] x, input bit tmo);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    for (int i = 0; i < 200 && !ok; i++) begin
      // in_ready depends only on registered state, so this value holds until the next edge
      if (bus.in_ready) begin
        e.data = tmo ? 16'hFFFF : ref_sqrt(x);
        e.err  = tmo;
        exp_q.push_back(e);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!ok) check("push_accept", {31'b0, ok}, 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.busy) done = 1'b1;
    end
    check("drain_done", {31'b0, done}, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_sq_reset", bus.sq_reset, 1);
    check("rst_busy", bus.busy, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bp_ops [6];
    logic [31:0] x;
    int unsigned k;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    repeat (3) @(negedge clk);

    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_sq_x", bus.sq_x, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_err", bus.err, 0);
    check("reset_sq_reset", bus.sq_reset, 1);
    reset = 1'b0;
    @(negedge clk);

    push_op(32'h0000_0000, 1'b0);
    drain();
    push_op(32'h0001_0000, 1'b0);
    push_op(32'hFFFF_FFFF, 1'b0);
    drain();

    // operand accepted at edge N: sq_reset rises after edge N+1, so the core samples it from edge N+2
    push_op(32'h0000_0019, 1'b0);
    check("latency_edge_n", bus.sq_reset, 0);
    @(negedge clk);
    check("latency_edge_n1", bus.sq_reset, 1);
    drain();

    // back-pressure: one in flight plus a full FIFO, then a sixth operand waits
    bp_ops = '{32'd49, 32'd50, 32'd1, 32'h00FF_FFFF, 32'd144, 32'd2};
    ready_val = 1'b0;
    for (int i = 0; i < 5; i++) push_op(bp_ops[i], 1'b0);
    fork
      push_op(bp_ops[5], 1'b0);
      begin
        repeat (30) @(negedge clk);
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_out_valid", bus.out_valid, 1);
        check("bp_queued", exp_q.size(), 5);
        ready_val = 1'b1;
      end
    join
    drain();
    check("bp_in_ready_after", bus.in_ready, 1);

    // core never answers
    stub_stuck = 1'b1;
`ifdef SQRT_FEED_TIMEOUT_EN
    push_op(32'h0000_0004, 1'b1);
    drain();
    check("tmo_err_cleared", bus.err, 0);
`else
    push_op(32'h0000_0004, 1'b0);
    repeat (100) @(negedge clk);
    check("stuck_busy", bus.busy, 1);
    check("stuck_out_valid", bus.out_valid, 0);
    do_reset();
`endif

    // reset while waiting on the core, with more operands queued behind it
    push_op(32'h1234_5678, 1'b0);
    push_op(32'h0000_0007, 1'b0);
    push_op(32'h0000_0009, 1'b0);
    repeat (HOLD + 6) @(negedge clk);
    check("wait_busy", bus.busy, 1);
    check("wait_sq_reset", bus.sq_reset, 0);
    check("wait_out_valid", bus.out_valid, 0);
    do_reset();
    stub_stuck = 1'b0;
    @(negedge clk);
    push_op(32'h0000_0064, 1'b0);
    drain();

    // randomized operands and consumer back-pressure
    ready_force = 1'b0;
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(1, 65535);
      case ($urandom_range(0, 5))
        0:       x = 32'h0;
        1:       x = 32'hFFFF_FFFF;
        2:       x = k * k;
        3:       x = k * k - 1;
        default: x = $urandom;
      endcase
      push_op(x, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    ready_force = 1'b1;

    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
